// File: rtl/smux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   SRC_A / SRC_B : source tag values, identical to the SMUX2x1 select encoding
//   state_t       : output-register occupancy state
package smux_arb_pkg;

  localparam logic SRC_A = 1'b1;
  localparam logic SRC_B = 1'b0;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/smux_rr_arbiter_if.sv
// Handshake bundle for smux_rr_arbiter.
//   a/aValid/aReady : requester A channel
//   b/bValid/bReady : requester B channel
//   d/dValid/dReady : registered output channel, dSrc tags its origin (1 = A)
//   cntA/cntB       : per-source accepted-transfer counters
// master = producers/consumer side, slave = arbiter side.
interface smux_rr_arbiter_if #(
  parameter int DATAWIDTH = 16,
  parameter int CNTW      = 8
);

  logic signed [DATAWIDTH-1:0] a;
  logic                        aValid;
  logic                        aReady;
  logic signed [DATAWIDTH-1:0] b;
  logic                        bValid;
  logic                        bReady;
  logic signed [DATAWIDTH-1:0] d;
  logic                        dValid;
  logic                        dReady;
  logic                        dSrc;
  logic [CNTW-1:0]             cntA;
  logic [CNTW-1:0]             cntB;

  modport master (
    output a, aValid, b, bValid, dReady,
    input  aReady, bReady, d, dValid, dSrc, cntA, cntB
  );

  modport slave (
    input  a, aValid, b, bValid, dReady,
    output aReady, bReady, d, dValid, dSrc, cntA, cntB
  );

endinterface

// File: rtl/smux_rr_arbiter_mux.sv
// SMUX2x1: signed 2:1 data select, sel = 1 picks a, sel = 0 picks b.
//   a, b : signed inputs (DATAWIDTH)
//   sel  : select
//   d    : selected value, sign and width preserved
module SMUX2x1 #(
  parameter int DATAWIDTH = 16
) (
  input  logic signed [DATAWIDTH-1:0] a,
  input  logic signed [DATAWIDTH-1:0] b,
  input  logic                        sel,
  output logic signed [DATAWIDTH-1:0] d
);

  always_comb begin
    d = sel ? a : b;
  end

endmodule

// File: rtl/smux_rr_arbiter.sv
// smux_rr_arbiter: round-robin sharing of one SMUX2x1 between two valid/ready
// requesters, feeding a single registered output with source tag and
// per-source transfer counters.
//   Clk : clock, rising edge
//   Rst : synchronous, active-low reset
//   bus : smux_rr_arbiter_if slave (requester A/B, output channel, counters)
module smux_rr_arbiter
  import smux_arb_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int CNTW      = 8
) (
  input logic              Clk,
  input logic              Rst,
  smux_rr_arbiter_if.slave bus
);

  state_t                      state;
  state_t                      state_nxt;
  logic                        last;
  logic                        can_load;
  logic                        gnt_a;
  logic                        gnt_b;
  logic                        sel;
  logic signed [DATAWIDTH-1:0] mux_d;

  SMUX2x1 #(
    .DATAWIDTH(DATAWIDTH)
  ) u_mux (
    .a  (bus.a),
    .b  (bus.b),
    .sel(sel),
    .d  (mux_d)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: any load cycle either refills the register or drains it
  always_comb begin
    state_nxt = state;
    if (can_load) begin
      state_nxt = (gnt_a || gnt_b) ? ST_FULL : ST_EMPTY;
    end
  end

  // Outputs: grant is gated by Rst so nothing is accepted in a reset cycle.
  // On a tie the source opposite to the last winner is served.
  always_comb begin
    can_load   = Rst && ((state == ST_EMPTY) || bus.dReady);
    gnt_a      = can_load && bus.aValid && (!bus.bValid || (last == SRC_B));
    gnt_b      = can_load && bus.bValid && !gnt_a;
    sel        = gnt_a ? SRC_A : SRC_B;
    bus.aReady = gnt_a;
    bus.bReady = gnt_b;
    bus.dValid = (state == ST_FULL);
  end

  // Output register, round-robin memory and counters
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      bus.d    <= '0;
      bus.dSrc <= SRC_B;
      last     <= SRC_B;
      bus.cntA <= '0;
      bus.cntB <= '0;
    end else if (gnt_a || gnt_b) begin
      bus.d    <= mux_d;
      bus.dSrc <= sel;
      last     <= sel;
      if (gnt_a) begin
        bus.cntA <= bus.cntA + 1'b1;
      end else begin
        bus.cntB <= bus.cntB + 1'b1;
      end
    end
  end

endmodule
